contrast_lut_ctrl: RTL and testbench

Configuration and sequencing controller for the gray-level contrast curve datapath.
- Host loads a new 256-entry 8-bit curve into a shadow bank through a simple write port.
- The controller swaps shadow and active banks only during vertical blanking (per_img_vsync low), so no frame is ever rendered with a mixed curve.
- The pixel stream (vsync/href/gray) passes through the active bank with fixed latency.
- Sits between the video source and downstream image processing; replaces a static combinational curve.

---
 rtl/contrast_pkg.sv | 16 +
 rtl/contrast_lut_bank.sv | 29 ++
 rtl/contrast_lut_ctrl.sv | 137 +++++++++++++
 tb/tb_contrast_lut_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contrast_pkg.sv
// Shared sizing constants and controller state encoding for the contrast curve block.
package contrast_pkg;

  localparam int LUT_DEPTH = 256;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = $clog2(LUT_DEPTH);
  localparam int PIX_LAT   = 2;
  localparam int CNT_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/contrast_lut_bank.sv
// Two-bank curve RAM, one write port and one registered read port; read latency 1 cycle.
// No backpressure: a write and a read are accepted every cycle.
module contrast_lut_bank
  import contrast_pkg::*;
(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2*LUT_DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
    r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/contrast_lut_ctrl.sv
// Double-buffered contrast curve: host loads the shadow bank, swap happens only in vertical blanking.
// Pixel path latency PIX_LAT (2) cycles; no backpressure, pixels and writes accepted every cycle.
module contrast_lut_ctrl
  import contrast_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0] cfg_wr_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic              cfg_wr_err,
  output logic              swap_pulse,
  output logic              active_bank,
  output logic              curve_valid,
  input  logic              per_img_vsync,
  input  logic              per_img_href,
  input  logic [DATA_W-1:0] per_img_gray,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_gray
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_active_bank;
  logic               r_curve_valid;
  logic               r_swap_pulse;
  logic               r_wr_err;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               w_busy;
  logic               w_wr_acc;
  logic               w_wr_rej;
  logic               w_swap;
  logic               w_cnt_clr;

  logic [PIX_LAT-1:0] r_vs_dly;
  logic [PIX_LAT-1:0] r_hr_dly;
  logic [PIX_LAT-1:0] r_cv_dly;
  logic [DATA_W-1:0]  r_gray_dly [PIX_LAT];
  logic               r_sel_s0;
  logic [DATA_W-1:0]  w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_start)      w_state_nxt = LOAD;
      LOAD:    if (cfg_commit)     w_state_nxt = PEND;
      PEND:    if (!per_img_vsync) w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == LOAD) || (r_state == PEND);
    w_wr_acc  = (r_state == LOAD) && cfg_wr_en;
    w_wr_rej  = (r_state != LOAD) && cfg_wr_en;
    w_swap    = (r_state == PEND) && !per_img_vsync;
    w_cnt_clr = cfg_start && ((r_state == IDLE) || (r_state == LOAD));
  end

  // Session bookkeeping; the write counter is a debug aid and never gates the swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_bank <= 1'b0;
      r_curve_valid <= 1'b0;
      r_swap_pulse  <= 1'b0;
      r_wr_err      <= 1'b0;
      r_wr_cnt      <= '0;
    end else begin
      r_swap_pulse <= w_swap;
      r_wr_err     <= w_wr_rej;
      if (w_swap) begin
        r_active_bank <= ~r_active_bank;
        r_curve_valid <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_wr_cnt <= w_wr_acc ? CNT_W'(1) : '0;
      end else if (w_wr_acc && (r_wr_cnt != CNT_W'(LUT_DEPTH))) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
    end
  end

  // Bank select and bypass flag travel with the pixel, so a swap never splits a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_dly <= '0;
      r_hr_dly <= '0;
      r_cv_dly <= '0;
      r_sel_s0 <= 1'b0;
      for (int i = 0; i < PIX_LAT; i++) begin
        r_gray_dly[i] <= '0;
      end
    end else begin
      r_vs_dly      <= {r_vs_dly[PIX_LAT-2:0], per_img_vsync};
      r_hr_dly      <= {r_hr_dly[PIX_LAT-2:0], per_img_href};
      r_cv_dly      <= {r_cv_dly[PIX_LAT-2:0], r_curve_valid};
      r_sel_s0      <= r_active_bank;
      r_gray_dly[0] <= per_img_gray;
      for (int i = 1; i < PIX_LAT; i++) begin
        r_gray_dly[i] <= r_gray_dly[i-1];
      end
    end
  end

  contrast_lut_bank u_bank (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_bank (~r_active_bank),
    .i_wr_addr (cfg_wr_addr),
    .i_wr_data (cfg_wr_data),
    .i_rd_bank (r_sel_s0),
    .i_rd_addr (r_gray_dly[0]),
    .o_rd_data (w_rd_data)
  );

  assign cfg_busy       = w_busy;
  assign cfg_wr_err     = r_wr_err;
  assign swap_pulse     = r_swap_pulse;
  assign active_bank    = r_active_bank;
  assign curve_valid    = r_curve_valid;
  assign post_img_vsync = r_vs_dly[PIX_LAT-1];
  assign post_img_href  = r_hr_dly[PIX_LAT-1];
  assign post_img_gray  = r_cv_dly[PIX_LAT-1] ? w_rd_data : r_gray_dly[PIX_LAT-1];

endmodule

// File: tb/tb_contrast_lut_ctrl.sv
// Randomized bench for contrast_lut_ctrl against a bank/session reference model.
module tb_contrast_lut_ctrl;
  import contrast_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_wr_en = 1'b0;
  logic [7:0] cfg_wr_addr = 8'h00;
  logic [7:0] cfg_wr_data = 8'h00;
  logic       cfg_commit = 1'b0;
  logic       per_img_vsync = 1'b0;
  logic       per_img_href = 1'b0;
  logic [7:0] per_img_gray = 8'h00;
  logic       cfg_busy, cfg_wr_err, swap_pulse, active_bank, curve_valid;
  logic       post_img_vsync, post_img_href;
  logic [7:0] post_img_gray;

  always #5 clk = ~clk;

  contrast_lut_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_commit     (cfg_commit),
    .cfg_busy       (cfg_busy),
    .cfg_wr_err     (cfg_wr_err),
    .swap_pulse     (swap_pulse),
    .active_bank    (active_bank),
    .curve_valid    (curve_valid),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_gray   (per_img_gray),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_gray  (post_img_gray)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit vs;
    bit hr;
    bit cv;
    bit sel;
    int g;
  } pix_t;

  int   mram   [2][256];
  bit   mknown [2][256];
  bit   m_act, m_cv, m_open, m_pend;
  pix_t pipe[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pix_t z;
    z = '{vs: 1'b0, hr: 1'b0, cv: 1'b0, sel: 1'b0, g: 0};
    m_act = 1'b0; m_cv = 1'b0; m_open = 1'b0; m_pend = 1'b0;
    pipe.delete();
    pipe.push_back(z);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    #1;
    check_eq("rst_busy",   32'(cfg_busy),       32'(0));
    check_eq("rst_err",    32'(cfg_wr_err),     32'(0));
    check_eq("rst_swap",   32'(swap_pulse),     32'(0));
    check_eq("rst_act",    32'(active_bank),    32'(0));
    check_eq("rst_valid",  32'(curve_valid),    32'(0));
    check_eq("rst_pvs",    32'(post_img_vsync), 32'(0));
    check_eq("rst_phref",  32'(post_img_href),  32'(0));
    check_eq("rst_pgray",  32'(post_img_gray),  32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: advance the model with the applied inputs, then compare every output.
  task automatic tick();
    pix_t cur, o;
    bit   exp_err, exp_swap;
    cur.vs = per_img_vsync; cur.hr = per_img_href;
    cur.cv = m_cv; cur.sel = m_act; cur.g = int'(per_img_gray);
    exp_err  = cfg_wr_en && !m_open;
    exp_swap = 1'b0;
    if (m_open && cfg_wr_en) begin
      mram[!m_act][cfg_wr_addr]   = int'(cfg_wr_data);
      mknown[!m_act][cfg_wr_addr] = 1'b1;
    end
    if (m_pend) begin
      if (!per_img_vsync) begin
        m_act = !m_act; m_cv = 1'b1; m_pend = 1'b0; exp_swap = 1'b1;
      end
    end else if (m_open) begin
      if (cfg_commit) begin m_open = 1'b0; m_pend = 1'b1; end
    end else if (cfg_start) begin
      m_open = 1'b1;
    end
    pipe.push_back(cur);
    o = pipe.pop_front();
    @(posedge clk);
    #1;
    cfg_start = 1'b0; cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    check_eq("busy",  32'(cfg_busy),       32'(m_open | m_pend));
    check_eq("err",   32'(cfg_wr_err),     32'(exp_err));
    check_eq("swap",  32'(swap_pulse),     32'(exp_swap));
    check_eq("act",   32'(active_bank),    32'(m_act));
    check_eq("valid", 32'(curve_valid),    32'(m_cv));
    check_eq("pvs",   32'(post_img_vsync), 32'(o.vs));
    check_eq("phref", 32'(post_img_href),  32'(o.hr));
    if (!o.cv)
      check_eq("gray_bypass", 32'(post_img_gray), 32'(o.g));
    else if (mknown[o.sel][o.g])
      check_eq("gray_curve", 32'(post_img_gray), 32'(mram[o.sel][o.g]));
  endtask

  task automatic rnd_pix(input bit vs);
    per_img_vsync = vs;
    per_img_href  = 1'($urandom_range(0, 1));
    per_img_gray  = 8'($urandom);
  endtask

  task automatic pix(input int n, input bit vs);
    for (int i = 0; i < n; i++) begin
      rnd_pix(vs);
      tick();
    end
  endtask

  // kind 0: inverse curve, kind 1: random curve; the session is left open.
  task automatic load(input int kind, input int cnt, input bit vs);
    cfg_start = 1'b1;
    rnd_pix(vs);
    tick();
    for (int i = 0; i < cnt; i++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 8'(i);
      cfg_wr_data = (kind == 0) ? 8'(255 - i) : 8'($urandom);
      rnd_pix(vs);
      tick();
      if ($urandom_range(0, 3) == 0) pix(1, vs);
    end
  endtask

  task automatic commit(input bit vs);
    cfg_commit = 1'b1;
    rnd_pix(vs);
    tick();
  endtask

  task automatic map_probe(input string tag, input logic [7:0] g, input logic [7:0] exp, input bit vs);
    per_img_vsync = vs; per_img_href = 1'b1; per_img_gray = g;
    tick();
    tick();
    check_eq(tag, 32'(post_img_gray), 32'(exp));
  endtask

  initial begin
    bit vs_lvl;
    #2;
    do_reset();

    for (int i = 0; i < 256; i++) begin
      per_img_vsync = 1'b1; per_img_href = 1'b1; per_img_gray = 8'(i);
      tick();
    end

    pix(4, 1'b0);
    load(0, 256, 1'b0);
    commit(1'b0);
    pix(1, 1'b0);
    check_eq("inv_act", 32'(active_bank), 32'(1));
    map_probe("inv_map10", 8'h10, 8'hEF, 1'b0);

    pix(3, 1'b1);
    load(0, 256, 1'b1);
    commit(1'b1);
    pix(10, 1'b1);
    cfg_wr_en = 1'b1; cfg_wr_addr = 8'h10; cfg_wr_data = 8'h55;
    rnd_pix(1'b1);
    tick();
    check_eq("pend_wr_err", 32'(cfg_wr_err), 32'(1));
    pix(10, 1'b1);
    pix(3, 1'b0);
    pix(50, 1'b1);
    map_probe("pend_map10", 8'h10, 8'hEF, 1'b1);

    pix(3, 1'b0);
    load(1, 100, 1'b0);
    #3;
    do_reset();
    check_eq("midload_busy", 32'(cfg_busy), 32'(0));
    pix(64, 1'b1);

    load(1, 256, 1'b0);
    commit(1'b0);
    pix(2, 1'b0);
    cfg_start = 1'b1; rnd_pix(1'b0); tick();
    cfg_wr_en = 1'b1; cfg_wr_addr = 8'h80; cfg_wr_data = 8'h00; rnd_pix(1'b0); tick();
    commit(1'b0);
    pix(2, 1'b0);
    map_probe("part_map80", 8'h80, 8'h00, 1'b1);
    map_probe("part_map7f", 8'h7F, 8'h80, 1'b1);
    for (int i = 0; i < 256; i++) begin
      per_img_vsync = 1'b1; per_img_href = 1'b1; per_img_gray = 8'(i);
      tick();
    end

    vs_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) vs_lvl = !vs_lvl;
      cfg_start   = ($urandom_range(0, 19) == 0);
      cfg_wr_en   = ($urandom_range(0, 2) == 0);
      cfg_wr_addr = 8'($urandom);
      cfg_wr_data = 8'($urandom);
      cfg_commit  = ($urandom_range(0, 29) == 0);
      rnd_pix(vs_lvl);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
